sm_rr_scheduler: RTL

- Round-robin scheduler that shares one enable-driven state-machine datapath among NUM_REQ requesters.
- The datapath has a clock, an `en` input and 2-bit outputs `dout0`/`dout1`.
- The scheduler grants one requester at a time and drives the datapath's `en` for a fixed burst of BURST_LEN cycles.
- It then releases the grant, pulses `done` and rotates priority. It sits directly between requester logic and the shared state machine.

---
 rtl/sm_rr_scheduler_if.sv | 26 ++
 rtl/sm_rr_scheduler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sm_rr_scheduler_if.sv
// rtl/sm_rr_scheduler_if.sv - requester/datapath bus of the round-robin burst scheduler
interface sm_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               sm_en;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   burst_cnt;

    // Scheduler side
    modport master (
        input  req,
        output gnt, gnt_idx, sm_en, busy, done, burst_cnt
    );

    // Requester / shared state machine side
    modport slave (
        output req,
        input  gnt, gnt_idx, sm_en, busy, done, burst_cnt
    );
endinterface

// File: rtl/sm_rr_scheduler.sv
// rtl/sm_rr_scheduler.sv - round-robin scheduler driving fixed-length sm_en bursts
// Optional early abort on grantee request drop: define SM_SCHED_ABORT_EN.
module sm_rr_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = 2,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sm_rr_scheduler_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic               sm_en_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   rr_ptr_q;

    logic               pick_valid_d;
    logic [IDX_W-1:0]   gnt_idx_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [IDX_W:0]     scan_sum;
    logic [IDX_W-1:0]   scan_idx;

    // Scan from the slot after the last grantee so ties resolve by rotation only.
    always_comb begin
        pick_valid_d = 1'b0;
        gnt_idx_d    = '0;
        scan_sum     = '0;
        scan_idx     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (scan_sum >= (IDX_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!pick_valid_d && bus.req[scan_idx]) begin
                pick_valid_d = 1'b1;
                gnt_idx_d    = scan_idx;
            end
        end
        gnt_d = NUM_REQ'(1) << gnt_idx_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            sm_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    cnt_q  <= '0;
                    if (pick_valid_d) begin
                        state_q   <= S_RUN;
                        gnt_q     <= gnt_d;
                        gnt_idx_q <= gnt_idx_d;
                        sm_en_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= S_RELEASE;
                        gnt_q    <= '0;
                        sm_en_q  <= 1'b0;
                        done_q   <= 1'b1;
                        rr_ptr_q <= gnt_idx_q;
`ifdef SM_SCHED_ABORT_EN
                    end else if (!bus.req[gnt_idx_q]) begin
                        // Counter still advances so it reports the cycles sm_en was high.
                        state_q  <= S_RELEASE;
                        gnt_q    <= '0;
                        sm_en_q  <= 1'b0;
                        done_q   <= 1'b1;
                        rr_ptr_q <= gnt_idx_q;
                        cnt_q    <= cnt_q + CNT_W'(1);
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    sm_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.sm_en     = sm_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.burst_cnt = cnt_q;

endmodule
